// File: rtl/frame_capture_ctrl_pkg.sv
// Shared types and helpers for the frame capture controller slice:
// FSM state encoding, frame width derivation and FIFO pointer sizing.
package frame_capture_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  function automatic int frame_width(input int ch_num, input int sample_w);
    return ch_num * sample_w;
  endfunction

  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_capture_ctrl_fifo.sv
// Synchronous frame FIFO with full/empty flags; a pop in the same cycle
// frees a slot so a push into a full FIFO still lands.
module frame_fifo
  import frame_capture_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = log2_ceil(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero when empty so the outputs read 0 out of reset.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/frame_capture_ctrl.sv
// Frame capture controller: turns the slow frame strobe into capture events,
// masks and sequence-tags frames, and buffers them onto a valid/ready stream.
module frame_capture_ctrl
  import frame_capture_ctrl_pkg::*;
#(
  parameter int  CH_NUM     = 32,
  parameter int  SAMPLE_W   = 16,
  parameter int  FIFO_DEPTH = 4,
  parameter int  SEQ_W      = 16,
  parameter int  CNT_W      = 16,
  localparam int FRAME_W    = frame_width(CH_NUM, SAMPLE_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_strobe,
  input  logic [FRAME_W-1:0] frame_data,
  input  logic               start_flag,
  input  logic               stop_flag,
  input  logic               single_shot,
  input  logic [SEQ_W-1:0]   frame_limit,
  input  logic [CH_NUM-1:0]  ch_mask,
  output logic [FRAME_W-1:0] out_frame,
  output logic [SEQ_W-1:0]   out_seq,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   overflow_cnt
);

  function automatic logic [FRAME_W-1:0] mask_frame(input logic [FRAME_W-1:0] d,
                                                    input logic [CH_NUM-1:0]  m);
    logic [FRAME_W-1:0] r;
    r = d;
    for (int i = 0; i < CH_NUM; i++) begin
      if (!m[i]) r[i*SAMPLE_W +: SAMPLE_W] = '0;
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic strobe_p0, strobe_p1, strobe_p2;
  logic vld_p0, vld_p1;
  logic cap_evt;
  logic start_q, stop_q, start_edge, stop_edge;

  state_e           state_q, state_d;
  logic             capture, reach_limit, seq_clr, drop, pop;
  logic [SEQ_W-1:0] seq_q, cap_cnt_q, limit_eff;
  logic [SEQ_W:0]   cnt_next;
  logic             fifo_full, fifo_empty;

  assign start_edge = start_flag & ~start_q;
  assign stop_edge  = stop_flag & ~stop_q;

  // Stage p0/p1 synchronise the strobe; p2 holds the previous level, primed
  // high until real samples arrive so a level already high at reset release
  // is not mistaken for a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_p0 <= 1'b0;
      strobe_p1 <= 1'b0;
      strobe_p2 <= 1'b1;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      cap_evt   <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      strobe_p0 <= frame_strobe;
      strobe_p1 <= strobe_p0;
      vld_p0    <= 1'b1;
      vld_p1    <= vld_p0;
      strobe_p2 <= vld_p1 ? strobe_p1 : 1'b1;
      cap_evt   <= vld_p1 & strobe_p1 & ~strobe_p2;
      start_q   <= start_flag;
      stop_q    <= stop_flag;
    end
  end

  assign limit_eff   = (frame_limit == '0) ? SEQ_W'(1) : frame_limit;
  assign cnt_next    = {1'b0, cap_cnt_q} + (SEQ_W+1)'(1);
  assign reach_limit = single_shot && (cnt_next >= {1'b0, limit_eff});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_edge && !stop_edge) state_d = ST_ARMED;
      ST_ARMED: begin
        if (stop_edge)    state_d = ST_IDLE;
        else if (cap_evt) state_d = reach_limit ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (stop_edge)                   state_d = ST_IDLE;
        else if (cap_evt && reach_limit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != ST_IDLE);
    capture = busy && cap_evt && !stop_edge;
    done    = ((state_q == ST_RUN) && (state_d == ST_IDLE)) ||
              ((state_q == ST_ARMED) && capture && reach_limit);
    seq_clr = (state_d == ST_IDLE) && (state_q != ST_IDLE);
  end

  assign pop  = out_valid && out_ready;
  assign drop = capture && fifo_full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q        <= '0;
      cap_cnt_q    <= '0;
      overflow_cnt <= '0;
    end else begin
      if (seq_clr) begin
        seq_q     <= '0;
        cap_cnt_q <= '0;
      end else if (capture) begin
        seq_q     <= seq_q + 1'b1;
        cap_cnt_q <= cap_cnt_q + 1'b1;
      end
      if (drop) overflow_cnt <= sat_inc(overflow_cnt);
    end
  end

  frame_fifo #(
    .WIDTH (FRAME_W + SEQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data ({seq_q, mask_frame(frame_data, ch_mask)}),
    .pop       (pop),
    .pop_data  ({out_seq, out_frame}),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;

endmodule
